pm_loader: RTL and testbench

//  Byte-stream program loader: the writer side of program memory. Receives a framed

---
 rtl/pm_loader.sv | 121 ++++++++++++
 tb/tb_pm_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pm_loader.sv
// Program-memory loader: receives a framed byte image (SYNC, N, N big-endian words, XOR csum),
// writes the words from address 0 and keeps the CPU held until a checksum-valid image is loaded.
module pm_loader #(
    parameter int          ADR_W     = 5,
    parameter int          DATA_W    = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              pm_we,
    output logic [ADR_W-1:0]  pm_adr,
    output logic [DATA_W-1:0] pm_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // state   | meaning
    // IDLE    | hunting for SYNC_BYTE, other bytes dropped
    // COUNT   | receiving word count N
    // HI      | receiving high byte of next word
    // LO      | receiving low byte of next word
    // WRITE   | one-cycle memory write of the assembled word
    // CSUM    | receiving and comparing the XOR checksum
    // DONE    | one-cycle success pulse, CPU released
    // ERR     | one-cycle error, sets sticky err
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam int          CW    = ADR_W + 1;
    localparam logic [31:0] MAX_N = 32'd1 << ADR_W;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt_n;
    logic [CW-1:0]   word_cnt;
    logic [7:0]      csum;
    logic            acc;
    logic            cnt_bad;
    logic            last_word;

    assign acc       = rx_valid && rx_ready;
    assign cnt_bad   = (rx_data == 8'd0) || ({24'd0, rx_data} > MAX_N);
    assign last_word = (word_cnt + CW'(1)) == cnt_n;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (acc && rx_data == SYNC_BYTE) state_nxt = S_COUNT;
            S_COUNT: if (acc) state_nxt = cnt_bad ? S_ERR : S_HI;
            S_HI:    if (acc) state_nxt = S_LO;
            S_LO:    if (acc) state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_word ? S_CSUM : S_HI;
            S_CSUM:  if (acc) state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        pm_we    = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE, S_COUNT, S_HI, S_LO, S_CSUM: rx_ready = 1'b1;
            S_WRITE: pm_we = 1'b1;
            S_DONE:  done  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: address/data hold their last value outside WRITE; pm_we qualifies them.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pm_adr   <= '0;
            pm_wdata <= '0;
            cpu_hold <= 1'b1;
            err      <= 1'b0;
            cnt_n    <= '0;
            word_cnt <= '0;
            csum     <= '0;
        end else begin
            case (state)
                S_IDLE: if (acc && rx_data == SYNC_BYTE) begin
                    cpu_hold <= 1'b1;
                    err      <= 1'b0;
                    pm_adr   <= '0;
                    csum     <= '0;
                    cnt_n    <= '0;
                    word_cnt <= '0;
                end
                S_COUNT: if (acc && !cnt_bad) cnt_n <= CW'(rx_data);
                S_HI: if (acc) begin
                    pm_wdata[15:8] <= rx_data;
                    csum           <= csum ^ rx_data;
                end
                S_LO: if (acc) begin
                    pm_wdata[7:0] <= rx_data;
                    csum          <= csum ^ rx_data;
                end
                S_WRITE: begin
                    word_cnt <= word_cnt + CW'(1);
                    if (!last_word) pm_adr <= pm_adr + ADR_W'(1);
                end
                S_CSUM: if (acc && rx_data == csum) cpu_hold <= 1'b0;
                S_ERR:  err <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pm_loader.sv
// Directed bench for pm_loader: frames with hand-picked words, checksum errors, bad counts,
// leading garbage, a full 32-word image with valid gaps, and a mid-frame reset.
module tb_pm_loader;

    logic        clk = 1'b0;
    logic        clr;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        pm_we;
    logic [4:0]  pm_adr;
    logic [15:0] pm_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] mem [0:31];
    logic [15:0] fw  [0:31];
    int          we_cnt   = 0;
    int          done_cnt = 0;
    int          rdy_bad  = 0;
    logic [4:0]  adr_q [$];

    pm_loader #(.ADR_W(5), .DATA_W(16), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .clr(clr), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .pm_we(pm_we), .pm_adr(pm_adr), .pm_wdata(pm_wdata), .cpu_hold(cpu_hold),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Memory model and pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (pm_we) begin
            mem[pm_adr] <= pm_wdata;
            we_cnt      <= we_cnt + 1;
            adr_q.push_back(pm_adr);
            if (rx_ready) rdy_bad <= rdy_bad + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; byte transfers at the first edge where rx_ready is high.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps) begin
            rx_valid = 1'b0;
            tick($urandom_range(0, 2));
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (!rx_ready && guard < 200) begin
            tick(1);
            guard++;
        end
        if (guard >= 200) begin
            chk("rx_ready timeout", 32'd0, 32'd1);
        end else begin
            tick(1);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit bad_csum, input bit gaps);
        logic [7:0] cs;
        cs = 8'h00;
        send_byte(8'hA5, gaps);
        send_byte(8'(n), gaps);
        for (int i = 0; i < n; i++) begin
            send_byte(fw[i][15:8], gaps);
            send_byte(fw[i][7:0], gaps);
            cs = cs ^ fw[i][15:8] ^ fw[i][7:0];
        end
        send_byte(bad_csum ? 8'h00 : cs, gaps);
    endtask

    int exp_we;
    int exp_done;
    int q0;
    int bad;

    initial begin
        clr      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        chk("rst rx_ready", rx_ready, 1);
        chk("rst pm_we", pm_we, 0);
        chk("rst pm_adr", pm_adr, 0);
        chk("rst pm_wdata", pm_wdata, 0);
        chk("rst cpu_hold", cpu_hold, 1);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        @(negedge clk);
        clr = 1'b0;
        tick(1);

        // 1: two words, checksum 12^34^AB^CD = 40
        fw[0] = 16'h1234; fw[1] = 16'hABCD;
        send_frame(2, 1'b0, 1'b0);
        chk("t1 done pulse", done, 1);
        chk("t1 cpu_hold released", cpu_hold, 0);
        tick(1);
        chk("t1 done one cycle", done, 0);
        chk("t1 cpu_hold stays 0", cpu_hold, 0);
        chk("t1 word0", mem[0], 16'h1234);
        chk("t1 word1", mem[1], 16'hABCD);
        chk("t1 we count", we_cnt, 2);
        chk("t1 done count", done_cnt, 1);
        exp_we = 2; exp_done = 1;

        // 2: same frame with csum 00; SYNC re-holds CPU immediately
        fw[0] = 16'h5566; fw[1] = 16'h7788;
        send_byte(8'hA5, 1'b0);
        chk("t2 hold after sync", cpu_hold, 1);
        send_byte(8'h02, 1'b0);
        for (int i = 0; i < 2; i++) begin
            send_byte(fw[i][15:8], 1'b0);
            send_byte(fw[i][7:0], 1'b0);
        end
        send_byte(8'h00, 1'b0);
        tick(2);
        exp_we += 2;
        chk("t2 err", err, 1);
        chk("t2 cpu_hold", cpu_hold, 1);
        chk("t2 no done", done_cnt, exp_done);
        chk("t2 words written", we_cnt, exp_we);
        chk("t2 word1", mem[1], 16'h7788);

        // 3: bad counts 00 and 21, then a frame whose word contains the sync value
        send_byte(8'hA5, 1'b0);
        chk("t3 err cleared by sync", err, 0);
        send_byte(8'h00, 1'b0);
        tick(2);
        chk("t3 err count 00", err, 1);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h21, 1'b0);
        tick(2);
        chk("t3 err count 21", err, 1);
        chk("t3 no writes", we_cnt, exp_we);
        fw[0] = 16'hA5A5;
        send_frame(1, 1'b0, 1'b0);
        tick(1);
        exp_we += 1; exp_done += 1;
        chk("t3 err cleared", err, 0);
        chk("t3 done", done_cnt, exp_done);
        chk("t3 word0", mem[0], 16'hA5A5);

        // 4: leading garbage is discarded
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        chk("t4 garbage no hold", cpu_hold, 0);
        fw[0] = 16'hBEEF;
        send_frame(1, 1'b0, 1'b0);
        tick(1);
        exp_we += 1; exp_done += 1;
        chk("t4 word0", mem[0], 16'hBEEF);
        chk("t4 done", done_cnt, exp_done);

        // 5: full 32-word image with random valid gaps
        for (int i = 0; i < 32; i++) fw[i] = {8'(i), ~8'(i)} ^ 16'h3C00;
        q0 = adr_q.size();
        send_frame(32, 1'b0, 1'b1);
        chk("t5 cpu_hold released", cpu_hold, 0);
        tick(1);
        exp_we += 32; exp_done += 1;
        chk("t5 we count", we_cnt, exp_we);
        chk("t5 done", done_cnt, exp_done);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (adr_q[q0 + i] !== 5'(i)) bad++;
            if (mem[i] !== ({8'(i), ~8'(i)} ^ 16'h3C00)) bad++;
        end
        chk("t5 addr/data errors", bad, 0);
        chk("t5 adr no wrap", pm_adr, 31);
        chk("t5 rx_ready low in write", rdy_bad, 0);

        // 6: reset after the third word of a four-word frame
        fw[0] = 16'h1111; fw[1] = 16'h2222; fw[2] = 16'h3333;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h04, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_byte(fw[i][15:8], 1'b0);
            send_byte(fw[i][7:0], 1'b0);
        end
        tick(1);
        exp_we += 3;
        #2 clr = 1'b1;
        #1;
        chk("t6 rst pm_adr", pm_adr, 0);
        chk("t6 rst pm_wdata", pm_wdata, 0);
        chk("t6 rst cpu_hold", cpu_hold, 1);
        chk("t6 rst rx_ready", rx_ready, 1);
        chk("t6 rst pm_we", pm_we, 0);
        @(negedge clk);
        clr = 1'b0;
        tick(1);
        chk("t6 word2 kept", mem[2], 16'h3333);
        chk("t6 we count", we_cnt, exp_we);
        fw[0] = 16'hC0DE; fw[1] = 16'hF00D;
        send_frame(2, 1'b0, 1'b0);
        chk("t6 reload released", cpu_hold, 0);
        tick(1);
        exp_we += 2; exp_done += 1;
        chk("t6 reload word0", mem[0], 16'hC0DE);
        chk("t6 reload word1", mem[1], 16'hF00D);
        chk("t6 done", done_cnt, exp_done);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
